// File: rtl/mips_alu_md.sv
// Registered MIPS EX-stage ALU with OpALU/funct decode, plus an iterative
// shift-add multiplier / restoring divider writing the HI/LO pair.
module mips_alu_md #(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       OpALU,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] outputULA,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             illegal,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_saved;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    logic [WIDTH-1:0] sc_result;
    logic             sc_illegal;
    logic             md_req;
    logic             md_div;
    logic             md_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   hi_fin;
    logic [WIDTH-1:0]   lo_fin;

    assign busy = (state == S_MUL) || (state == S_DIV);
    assign zero = (outputULA == '0);

    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        md_req     = 1'b0;
        md_div     = 1'b0;
        md_signed  = 1'b0;
        case (OpALU)
            2'b00: sc_result = a + b;
            2'b01: sc_result = a - b;
            2'b10: begin
                case (funct)
                    F_ADD, F_ADDU: sc_result = a + b;
                    F_SUB, F_SUBU: sc_result = a - b;
                    F_AND:  sc_result = a & b;
                    F_OR:   sc_result = a | b;
                    F_XOR:  sc_result = a ^ b;
                    F_NOR:  sc_result = ~(a | b);
                    F_SLT:  sc_result = ($signed(a) < $signed(b)) ? ONE : '0;
                    F_SLTU: sc_result = (a < b) ? ONE : '0;
                    F_MFHI: begin
                        if (MD_EN) sc_result = hi;
                        else       sc_illegal = 1'b1;
                    end
                    F_MFLO: begin
                        if (MD_EN) sc_result = lo;
                        else       sc_illegal = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        if (MD_EN) begin
                            md_req    = 1'b1;
                            md_div    = funct[1];
                            md_signed = ~funct[0];
                        end else begin
                            sc_illegal = 1'b1;
                        end
                    end
                    default: sc_illegal = 1'b1;
                endcase
            end
            default: sc_illegal = 1'b1;
        endcase
    end

    // Both engines work on magnitudes; the sign fix-up happens once at FIN.
    always_comb begin
        a_neg = md_signed & a[WIDTH-1];
        b_neg = md_signed & b[WIDTH-1];
        a_mag = a_neg ? (~a + ONE) : a;
        b_mag = b_neg ? (~b + ONE) : b;
    end

    // acc_lo holds the multiplier (mul) or the dividend shifting into the quotient (div).
    always_comb begin
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_next = {add_sum, acc_lo[WIDTH-1:1]};
        shifted  = {acc_hi, acc_lo[WIDTH-1]};
        ge       = (shifted >= {1'b0, opnd});
        diff     = shifted[WIDTH-1:0] - opnd;
        rem_next = ge ? diff : shifted[WIDTH-1:0];
        quo_next = {acc_lo[WIDTH-2:0], ge};
    end

    always_comb begin
        prod_s = neg_res ? (~mul_next + 1'b1) : mul_next;
        hi_fin = '0;
        lo_fin = '0;
        if (state == S_MUL) begin
            {hi_fin, lo_fin} = prod_s;
        end else if (div_zero) begin
            hi_fin = a_saved;
            lo_fin = '1;
        end else begin
            hi_fin = neg_rem ? (~rem_next + ONE) : rem_next;
            lo_fin = neg_res ? (~quo_next + ONE) : quo_next;
        end
    end

    // FIN behaves like IDLE for new requests, so a start on that edge is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            outputULA <= '0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            div0      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            a_saved   <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_FIN: begin
                    state <= S_IDLE;
                    if (start) begin
                        if (md_req) begin
                            state    <= md_div ? S_DIV : S_MUL;
                            count    <= '0;
                            acc_hi   <= '0;
                            acc_lo   <= md_div ? a_mag : b_mag;
                            opnd     <= md_div ? b_mag : a_mag;
                            a_saved  <= a;
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            div_zero <= md_div && (b == '0);
                        end else begin
                            outputULA <= sc_result;
                            illegal   <= sc_illegal;
                            div0      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    count <= count + 1'b1;
                    if (state == S_MUL) begin
                        {acc_hi, acc_lo} <= mul_next;
                    end else begin
                        acc_hi <= rem_next;
                        acc_lo <= quo_next;
                    end
                    if (count == LAST) begin
                        state     <= S_FIN;
                        hi        <= hi_fin;
                        lo        <= lo_fin;
                        outputULA <= lo_fin;
                        illegal   <= 1'b0;
                        div0      <= div_zero;
                        done      <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_md.sv
// Bench for mips_alu_md: directed table, hand-written multi-cycle sequences and
// random ops against an arithmetic reference model, at WIDTH 32 and 8.
module tb_mips_alu_md;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero, done, busy, ill, dz;

    logic        start8;
    logic [1:0]  op8;
    logic [5:0]  fn8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  res8;
    logic        zero8, done8, busy8, ill8, dz8;

    mips_alu_md #(.WIDTH(32), .MD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .OpALU(op), .funct(fn),
        .a(a), .b(b), .outputULA(res), .zero(zero), .done(done),
        .busy(busy), .illegal(ill), .div0(dz)
    );

    mips_alu_md #(.WIDTH(8), .MD_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .OpALU(op8), .funct(fn8),
        .a(a8), .b(b8), .outputULA(res8), .zero(zero8), .done(done8),
        .busy(busy8), .illegal(ill8), .div0(dz8)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi, m_lo, m_hi8, m_lo8;

    logic [5:0] functs [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                6'b101010, 6'b101011, F_MULT, F_MULTU,
                                F_DIV, F_DIVU, F_MFHI, F_MFLO};

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        logic        dz;
        int          lat;
    } vec_t;
    vec_t tbl [19];

    // Reference: plain wide arithmetic on the w-bit operands.
    function automatic void model(input logic [1:0] o, input logic [5:0] f,
                                  input logic [31:0] va, input logic [31:0] vb, input int w,
                                  inout logic [31:0] hi, inout logic [31:0] lo,
                                  output logic [31:0] r, output logic il,
                                  output logic dzo, output int lat);
        logic [63:0] mask, ua, ub, p;
        longint sa, sb, q, rm;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, va} & mask;
        ub = {32'd0, vb} & mask;
        sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        r = '0; il = 1'b0; dzo = 1'b0; lat = 1;
        if (o == 2'b00) r = 32'((ua + ub) & mask);
        else if (o == 2'b01) r = 32'((ua - ub) & mask);
        else if (o == 2'b11) il = 1'b1;
        else begin
            case (f)
                6'b100000, 6'b100001: r = 32'((ua + ub) & mask);
                6'b100010, 6'b100011: r = 32'((ua - ub) & mask);
                6'b100100: r = 32'(ua & ub);
                6'b100101: r = 32'(ua | ub);
                6'b100110: r = 32'(ua ^ ub);
                6'b100111: r = 32'(~(ua | ub) & mask);
                6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
                6'b101011: r = (ua < ub) ? 32'd1 : 32'd0;
                F_MFHI: r = hi;
                F_MFLO: r = lo;
                F_MULT, F_MULTU: begin
                    p = (f == F_MULT) ? 64'(sa * sb) : ua * ub;
                    hi = 32'((p >> w) & mask);
                    lo = 32'(p & mask);
                    r = lo; lat = w + 1;
                end
                F_DIV, F_DIVU: begin
                    lat = w + 1;
                    if (ub == 64'd0) begin
                        lo = 32'(mask); hi = 32'(ua); dzo = 1'b1;
                    end else if (f == F_DIV) begin
                        q = sa / sb; rm = sa % sb;
                        lo = 32'(64'(q) & mask); hi = 32'(64'(rm) & mask);
                    end else begin
                        lo = 32'((ua / ub) & mask); hi = 32'((ua % ub) & mask);
                    end
                    r = lo;
                end
                default: il = 1'b1;
            endcase
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit w8, input logic [1:0] o, input logic [5:0] f,
                                 input logic [31:0] va, input logic [31:0] vb, output int lat);
        @(negedge clk);
        if (w8) begin start8 = 1'b1; op8 = o; fn8 = f; a8 = va[7:0]; b8 = vb[7:0]; end
        else    begin start  = 1'b1; op  = o; fn  = f; a  = va;      b  = vb;      end
        @(posedge clk);
        #1 start = 1'b0; start8 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!(w8 ? done8 : done) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkAll(input string tag, input bit w8, input logic [31:0] e_res,
                            input logic e_ill, input logic e_dz, input int e_lat, input int lat);
        checkOutput({tag, " result"},  w8 ? {24'd0, res8} : res, e_res);
        checkOutput({tag, " zero"},    32'(w8 ? zero8 : zero), 32'(e_res == 32'd0));
        checkOutput({tag, " illegal"}, 32'(w8 ? ill8 : ill), 32'(e_ill));
        checkOutput({tag, " div0"},    32'(w8 ? dz8 : dz), 32'(e_dz));
        checkOutput({tag, " latency"}, 32'(lat), 32'(e_lat));
    endtask

    function automatic logic [31:0] randVal(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'd1 << (w - 1);
            3: v = '1;
            default: v = $urandom;
        endcase
        return (w == 32) ? v : (v & ((32'd1 << w) - 32'd1));
    endfunction

    task automatic randomBurst(input bit w8, input int n, inout logic [31:0] hi, inout logic [31:0] lo);
        for (int i = 0; i < n; i++) begin
            logic [1:0] o;
            logic [5:0] f;
            logic [31:0] va, vb, er;
            logic ei, ed;
            int el, lat, w, sel;
            w = w8 ? 8 : 32;
            sel = $urandom_range(0, 9);
            o = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 15)];
            va = randVal(w);
            vb = randVal(w);
            model(o, f, va, vb, w, hi, lo, er, ei, ed, el);
            applyStimulus(w8, o, f, va, vb, lat);
            checkAll($sformatf("rnd%0d w%0d op%0b fn%06b", i, w, o, f), w8, er, ei, ed, el, lat);
            @(negedge clk);
            checkOutput("done pulse", 32'(w8 ? done8 : done), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, el, bc, dcnt, dcyc;
        logic [31:0] er, dres;
        logic ei, ed;

        tbl[0]  = '{2'b10, 6'b100010, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 1};
        tbl[1]  = '{2'b10, 6'b101010, 32'd5,        32'd7,        32'd1,        1'b0, 1'b0, 1};
        tbl[2]  = '{2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1};
        tbl[3]  = '{2'b01, 6'b000000, 32'h1234,     32'h1234,     32'd0,        1'b0, 1'b0, 1};
        tbl[4]  = '{2'b11, 6'b100000, 32'd1,        32'd2,        32'd0,        1'b1, 1'b0, 1};
        tbl[5]  = '{2'b10, F_MULT,    32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 1'b0, 1'b0, 33};
        tbl[6]  = '{2'b10, F_MFHI,    32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1};
        tbl[7]  = '{2'b10, F_MULTU,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 1'b0, 1'b0, 33};
        tbl[8]  = '{2'b10, F_MFHI,    32'd0,        32'd0,        32'd2,        1'b0, 1'b0, 1};
        tbl[9]  = '{2'b10, F_DIV,     32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 33};
        tbl[10] = '{2'b10, F_MFHI,    32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1};
        tbl[11] = '{2'b10, F_MFLO,    32'd0,        32'd0,        32'hFFFFFFFD, 1'b0, 1'b0, 1};
        tbl[12] = '{2'b10, F_DIVU,    32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 33};
        tbl[13] = '{2'b10, F_MFHI,    32'd0,        32'd0,        32'd7,        1'b0, 1'b0, 1};
        tbl[14] = '{2'b10, F_DIV,     32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 33};
        tbl[15] = '{2'b10, F_MFHI,    32'd0,        32'd0,        32'd0,        1'b0, 1'b0, 1};
        tbl[16] = '{2'b10, 6'b111111, 32'd3,        32'd4,        32'd0,        1'b1, 1'b0, 1};
        tbl[17] = '{2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1};
        tbl[18] = '{2'b10, 6'b100111, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1};

        rst_n = 1'b0;
        start = 1'b0; op = '0; fn = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; fn8 = '0; a8 = '0; b8 = '0;
        m_hi = '0; m_lo = '0; m_hi8 = '0; m_lo8 = '0;
        #12;
        checkOutput("reset result",  res, 32'd0);
        checkOutput("reset zero",    32'(zero), 32'd1);
        checkOutput("reset done",    32'(done), 32'd0);
        checkOutput("reset busy",    32'(busy), 32'd0);
        checkOutput("reset illegal", 32'(ill), 32'd0);
        checkOutput("reset div0",    32'(dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            model(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, 32, m_hi, m_lo, er, ei, ed, el);
            applyStimulus(1'b0, tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, lat);
            checkAll($sformatf("vec%0d", i), 1'b0, tbl[i].exp, tbl[i].ill, tbl[i].dz, tbl[i].lat, lat);
        end

        // mult with a stray start pulsed mid-iteration: busy 32 cycles, one done at 33.
        @(negedge clk);
        start = 1'b1; op = 2'b10; fn = F_MULT; a = 32'hFFFFFFFE; b = 32'd3;
        model(2'b10, F_MULT, 32'hFFFFFFFE, 32'd3, 32, m_hi, m_lo, er, ei, ed, el);
        @(posedge clk);
        #1 start = 1'b0;
        bc = 0; dcnt = 0; dcyc = 0; dres = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dcnt++;
                if (dcyc == 0) begin dcyc = i; dres = res; end
            end
            if (i == 10) begin start = 1'b1; op = 2'b00; fn = '0; a = 32'd1; b = 32'd1; end
            else start = 1'b0;
        end
        checkOutput("busy cycles", 32'(bc), 32'd32);
        checkOutput("busy done cycle", 32'(dcyc), 32'd33);
        checkOutput("busy done count", 32'(dcnt), 32'd1);
        checkOutput("busy mult LO", dres, 32'hFFFFFFFA);

        // divu then mfhi started on the FIN edge.
        model(2'b10, F_DIVU, 32'd100, 32'd7, 32, m_hi, m_lo, er, ei, ed, el);
        applyStimulus(1'b0, 2'b10, F_DIVU, 32'd100, 32'd7, lat);
        checkAll("b2b divu", 1'b0, 32'd14, 1'b0, 1'b0, 33, lat);
        start = 1'b1; op = 2'b10; fn = F_MFHI;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("b2b done", 32'(done), 32'd1);
        checkOutput("b2b mfhi", res, 32'd2);

        randomBurst(1'b0, 50, m_hi, m_lo);

        // Reset mid-divide aborts it and clears HI/LO.
        applyStimulus(1'b0, 2'b10, 6'b100101, 32'h5, 32'h0, lat);
        @(negedge clk);
        start = 1'b1; op = 2'b10; fn = F_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset result", res, 32'd0);
        checkOutput("midreset busy",   32'(busy), 32'd0);
        checkOutput("midreset zero",   32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        applyStimulus(1'b0, 2'b10, F_MFHI, 32'd0, 32'd0, lat);
        checkOutput("midreset HI", res, 32'd0);
        applyStimulus(1'b0, 2'b10, F_MFLO, 32'd0, 32'd0, lat);
        checkOutput("midreset LO", res, 32'd0);

        // WIDTH = 8: most-negative / -1.
        applyStimulus(1'b1, 2'b10, F_DIV, 32'h80, 32'hFF, lat);
        checkAll("w8 div", 1'b1, 32'h80, 1'b0, 1'b0, 9, lat);
        applyStimulus(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0, lat);
        checkOutput("w8 mfhi", {24'd0, res8}, 32'd0);
        m_hi8 = 32'h00; m_lo8 = 32'h80;
        randomBurst(1'b1, 30, m_hi8, m_lo8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_alu_md.md
Name: mips_alu_md

Overview:
- Parametrised, registered MIPS ALU with integrated ALU-control decode from OpALU and funct.
- Adds an iterative multiply/divide unit with HI/LO registers, driven by a start/busy/done handshake.
- Sits in the EX stage; single-cycle ops return a result one clock after start, mult/div after WIDTH+1 clocks.

Parameters:
WIDTH, 32, datapath width in bits (>=4); a, b, outputULA, HI, LO are all WIDTH bits.
MD_EN, 1, 1 = mult/div/mfhi/mflo implemented; 0 = those functs treated as illegal.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; OpALU/funct/a/b sampled on the same edge
OpALU  in  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type (use funct), 11 = illegal
funct  in  6  R-type function field
a  in  WIDTH  operand rs
b  in  WIDTH  operand rt
outputULA  out  WIDTH  registered result
zero  out  1  registered; 1 when outputULA == 0
done  out  1  one-cycle pulse: outputULA, zero, illegal, div0 valid
busy  out  1  high while a mult/div is iterating
illegal  out  1  registered; undecodable OpALU/funct
div0  out  1  registered; division by zero

Behaviour:
- Reset (rst_n low, asynchronous): outputULA, HI, LO = 0; zero = 1; done, busy, illegal, div0 = 0; FSM = IDLE. Reset mid-operation aborts the iteration; HI/LO are not updated.
- FSM states and transitions:
  - IDLE: on start with a single-cycle op, the result is registered at that edge; done = 1 the following cycle.
  - IDLE -> MUL or DIV: on start with mult/multu/div/divu; busy = 1 from the next cycle.
  - MUL/DIV: one iteration per clock, exactly WIDTH iterations.
  - MUL/DIV -> FIN: after the WIDTH-th iteration.
  - FIN: HI/LO written, outputULA = LO, done = 1, busy = 0; returns to IDLE.
  - Total: done asserts WIDTH+1 cycles after the start edge.
- start while busy is ignored: no state change, no done.
- start on the same edge as FIN is accepted as a new request.
- Decode:
  - OpALU = 00: a+b. OpALU = 01: a-b.
  - OpALU = 10, single-cycle functs: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu.
  - OpALU = 10, mult/div functs: 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - OpALU = 10, HI/LO moves: 010000 mfhi, 010010 mflo (single-cycle; return HI/LO as of the start edge).
- Illegal case: OpALU = 11 or an unlisted funct -> outputULA = 0, illegal = 1, done pulses after 1 cycle; HI/LO unchanged.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow trap.
  - slt/sltu give 1 or 0, zero-extended.
  - zero is computed from the registered outputULA.
- Multiply:
  - Shift-add on magnitudes; signed mult negates the 2*WIDTH product when the operand signs differ.
  - Result {HI, LO} = full 2*WIDTH product.
- Divide:
  - Restoring division on magnitudes; signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - Most-negative / -1: LO = most-negative value, HI = 0, no flag.
- Division by zero (b == 0): still runs WIDTH+1 cycles; LO = all ones, HI = a, div0 = 1 with done.
- illegal and div0 hold until the next done.

Test Plan:
- Reset: assert rst_n low mid-divide -> outputULA = 0, busy = 0, zero = 1 immediately; HI = LO = 0 after release.
- OpALU = 10, funct = 100010, a = 5, b = 7 -> done at cycle 1, outputULA = 0xFFFFFFFE. Same with funct = 101010 -> 1; with 101011 and a = 0xFFFFFFFF, b = 1 -> 0.
- OpALU = 01, a = b = 0x1234 -> outputULA = 0, zero = 1. OpALU = 11 -> illegal = 1, outputULA = 0.
- mult, a = 0xFFFFFFFE (-2), b = 3 -> busy for 32 cycles, done at cycle 33, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. multu with the same operands -> HI = 2, LO = 0xFFFFFFFA. A start pulsed during busy is ignored.
- div, a = -7, b = 2 -> LO = -3, HI = -1. divu, a = 7, b = 0 -> LO = 0xFFFFFFFF, HI = 7, div0 = 1.
- mfhi/mflo after the div -> return -1 and -3; a back-to-back start on the FIN edge is accepted. Repeat with WIDTH = 8: 0x80 div 0xFF -> LO = 0x80, HI = 0, done at cycle 9.
